// File: rtl/softmax_pkg.sv
// Shared definitions for softmax_approx and its input packer: vector geometry,
// padding value and the row-length mode encoding.
package softmax_pkg;

  localparam int          SM_LANES  = 64;
  localparam int          SM_DATA_W = 16;
  localparam logic [15:0] SM_PAD    = 16'h8000;

  typedef enum logic [1:0] {
    SM_LEN16,
    SM_LEN32,
    SM_LEN64,
    SM_LEN_RSVD
  } sm_mode_e;

  typedef enum logic {
    PK_IDLE,
    PK_FILL
  } pack_state_e;

  // Reserved mode is deliberately treated as the full 64-lane row.
  function automatic logic [6:0] sm_mode_len(input sm_mode_e mode);
    case (mode)
      SM_LEN16: return 7'd16;
      SM_LEN32: return 7'd32;
      default:  return 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/softmax_input_packer.sv
// Packs a serial Q6.10 score stream into one flat 64-lane vector per row for softmax_approx.
// Optional feature: SOFTMAX_PACK_SHORT_ROW_EN lets i_s_last terminate a row early.
module softmax_input_packer
  import softmax_pkg::*;
#(
  parameter int                DATA_W  = SM_DATA_W,
  parameter int                LANES   = SM_LANES,
  parameter logic [DATA_W-1:0] PAD_VAL = SM_PAD
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  input  logic [DATA_W-1:0]       i_s_data,
  input  logic                    i_s_last,
  input  logic [1:0]              i_length_mode,
  output logic                    o_valid,
  output logic [1:0]              o_length_mode,
  output logic [LANES*DATA_W-1:0] o_in_x_flat,
  output logic                    o_row_err
);

  localparam int CNT_W = $clog2(LANES);
  localparam int FLAT_W = LANES * DATA_W;

  pack_state_e         state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  sm_mode_e            mode_reg, mode_next;
  logic                err_reg, err_next;
  logic [FLAT_W-1:0]   build_reg, build_next;
  logic                valid_reg, valid_next;
  sm_mode_e            omode_reg, omode_next;
  logic [FLAT_W-1:0]   flat_reg, flat_next;
  logic                row_err_reg, row_err_next;

  logic                accept;
  sm_mode_e            cur_mode;
  logic                cur_err;
  logic [6:0]          row_len;
  logic [CNT_W-1:0]    last_idx;
  logic                full;
  logic                done;
  logic                framing_err;
  logic                rsvd;

  assign o_s_ready = i_en & ~i_rst;
  assign accept    = i_s_valid & o_s_ready;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    mode_next    = mode_reg;
    err_next     = err_reg;
    build_next   = build_reg;
    valid_next   = 1'b0;
    omode_next   = omode_reg;
    flat_next    = flat_reg;
    row_err_next = row_err_reg;

    // The first beat of a row takes its mode live; later beats use the latched copy.
    cur_mode = (state_reg == PK_IDLE) ? sm_mode_e'(i_length_mode) : mode_reg;
    cur_err  = (state_reg == PK_IDLE) ? 1'b0 : err_reg;
    row_len  = sm_mode_len(cur_mode);
    last_idx = CNT_W'(row_len - 7'd1);
    full     = (count_reg == last_idx);
    rsvd     = (cur_mode == SM_LEN_RSVD);

`ifdef SOFTMAX_PACK_SHORT_ROW_EN
    done        = full | i_s_last;
    framing_err = full & ~i_s_last;
`else
    done        = full;
    framing_err = full ^ i_s_last;
`endif

    if (accept) begin
      build_next[int'(count_reg)*DATA_W +: DATA_W] = i_s_data;
      if (done) begin
        valid_next   = 1'b1;
        flat_next    = build_next;
        omode_next   = rsvd ? SM_LEN64 : cur_mode;
        row_err_next = cur_err | framing_err | rsvd;
        build_next   = {LANES{PAD_VAL}};
        count_next   = '0;
        err_next     = 1'b0;
        state_next   = PK_IDLE;
      end else begin
        count_next = count_reg + 1'b1;
        mode_next  = cur_mode;
        err_next   = cur_err | framing_err;
        state_next = PK_FILL;
      end
    end
  end

  // A low i_en freezes everything, including a pending output pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= PK_IDLE;
      count_reg   <= '0;
      mode_reg    <= SM_LEN16;
      err_reg     <= 1'b0;
      build_reg   <= {LANES{PAD_VAL}};
      valid_reg   <= 1'b0;
      omode_reg   <= SM_LEN16;
      flat_reg    <= '0;
      row_err_reg <= 1'b0;
    end else if (i_en) begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      mode_reg    <= mode_next;
      err_reg     <= err_next;
      build_reg   <= build_next;
      valid_reg   <= valid_next;
      omode_reg   <= omode_next;
      flat_reg    <= flat_next;
      row_err_reg <= row_err_next;
    end
  end

  assign o_valid       = valid_reg;
  assign o_length_mode = omode_reg;
  assign o_in_x_flat   = flat_reg;
  assign o_row_err     = row_err_reg;

endmodule

// File: tb/tb_softmax_input_packer.sv
// Scoreboard bench for softmax_input_packer: stimulus pushes expected rows, a monitor
// pops and checks each output pulse. Honors SOFTMAX_PACK_SHORT_ROW_EN.
module tb_softmax_input_packer;

  logic          clk = 1'b0;
  logic          i_rst, i_en, i_s_valid, i_s_last;
  logic          o_s_ready, o_valid, o_row_err;
  logic [15:0]   i_s_data;
  logic [1:0]    i_length_mode, o_length_mode;
  logic [1023:0] o_in_x_flat;

  typedef struct {
    logic [1023:0] flat;
    logic [1:0]    mode;
    logic          err;
    int            hi;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   hi_cnt = 0;
  int   last_pop = 0;
  int   rowi = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_input_packer dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .i_s_data(i_s_data), .i_s_last(i_s_last), .i_length_mode(i_length_mode),
    .o_valid(o_valid), .o_length_mode(o_length_mode), .o_in_x_flat(o_in_x_flat),
    .o_row_err(o_row_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flat(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    bit shown = 0;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      for (int k = 0; k < 64; k++) begin
        if (!shown && act[k*16 +: 16] !== exp[k*16 +: 16]) begin
          $display("FAIL %s lane %0d: got %h expected %h", name, k, act[k*16 +: 16], exp[k*16 +: 16]);
          shown = 1;
        end
      end
    end
  endtask

  // Row n lanes hold base, base+1, ...; the rest is padding.
  task automatic expect_row(input logic [15:0] base, input int n, input logic [1:0] m,
                            input logic err, input int hi, input int gap);
    exp_t e;
    e.flat = {64{16'h8000}};
    for (int k = 0; k < n; k++) e.flat[k*16 +: 16] = base + 16'(k);
    e.mode = m;
    e.err  = err;
    e.hi   = hi;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic stall(input int n);
    i_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    i_en = 1'b1;
  endtask

  task automatic send_row(input int nb, input logic [1:0] m, input logic [1:0] m_late, input int sw_at,
                          input int last_at, input logic [15:0] base, input int stall_at, input bit stall_out);
    for (int i = 0; i < nb; i++) begin
      i_s_valid     = 1'b1;
      i_s_data      = base + 16'(i);
      i_s_last      = (i + 1 == last_at);
      i_length_mode = (i >= sw_at) ? m_late : m;
      @(posedge clk); #1;
      if (i + 1 == stall_at) begin
        i_s_data = base + 16'(i + 1);
        i_s_last = 1'b0;
        i_en = 1'b0;
        @(negedge clk);
        chk("ready_low_in_stall", 32'(o_s_ready), 32'd0);
        @(posedge clk); #1;
        stall(4);
      end
    end
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    if (stall_out) stall(5);
  endtask

  task automatic idle(input int n);
    i_s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: a pulse ends on the first enabled cycle while o_valid is high.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      hi_cnt++;
      if (i_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_o_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk_flat($sformatf("row%0d_flat", rowi), o_in_x_flat, e.flat);
          chk($sformatf("row%0d_mode", rowi), 32'(o_length_mode), 32'(e.mode));
          chk($sformatf("row%0d_err", rowi), 32'(o_row_err), 32'(e.err));
          chk($sformatf("row%0d_valid_width", rowi), 32'(hi_cnt), 32'(e.hi));
          if (e.gap != 0) chk($sformatf("row%0d_gap", rowi), 32'(cyc - last_pop), 32'(e.gap));
          $display("row %0d: mode=%0d err=%0d lane0=%h high=%0d", rowi, o_length_mode, o_row_err,
                   o_in_x_flat[15:0], hi_cnt);
        end
        last_pop = cyc;
        rowi++;
        hi_cnt = 0;
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_s_valid = 1'b0; i_s_last = 1'b0;
    i_s_data = '0; i_length_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_mode", 32'(o_length_mode), 32'd0);
    chk("reset_o_err", 32'(o_row_err), 32'd0);
    chk_flat("reset_flat", o_in_x_flat, 1024'd0);
    chk("reset_ready", 32'(o_s_ready), 32'd0);
    i_rst = 1'b0;
    idle(2);

    // 1: mode 0 row of 1..16
    expect_row(16'h0001, 16, 2'd0, 1'b0, 1, 0);
    send_row(16, 2'd0, 2'd0, 99, 16, 16'h0001, 0, 0);
    idle(3);

    // 2: three back-to-back 64-element rows
    expect_row(16'h1000, 64, 2'd2, 1'b0, 1, 0);
    expect_row(16'h1100, 64, 2'd2, 1'b0, 1, 64);
    expect_row(16'h1200, 64, 2'd2, 1'b0, 1, 64);
    send_row(64, 2'd2, 2'd2, 99, 64, 16'h1000, 0, 0);
    send_row(64, 2'd2, 2'd2, 99, 64, 16'h1100, 0, 0);
    send_row(64, 2'd2, 2'd2, 99, 64, 16'h1200, 0, 0);
    idle(3);

    // 3: mode 1 with a stall mid-row and a stall over the output pulse
    expect_row(16'h2000, 32, 2'd1, 1'b0, 6, 0);
    send_row(32, 2'd1, 2'd1, 99, 32, 16'h2000, 10, 1);
    idle(3);

    // 4: early last on beat 20 of a mode 1 row
`ifdef SOFTMAX_PACK_SHORT_ROW_EN
    expect_row(16'h3000, 20, 2'd1, 1'b0, 1, 0);
    send_row(20, 2'd1, 2'd1, 99, 20, 16'h3000, 0, 0);
`else
    expect_row(16'h3000, 32, 2'd1, 1'b1, 1, 0);
    send_row(32, 2'd1, 2'd1, 99, 20, 16'h3000, 0, 0);
`endif
    idle(3);

    // 5: reserved mode, mid-row mode switch, and missing last
    expect_row(16'h4000, 64, 2'd2, 1'b1, 1, 0);
    send_row(64, 2'd3, 2'd3, 99, 64, 16'h4000, 0, 0);
    idle(2);
    expect_row(16'h5000, 16, 2'd0, 1'b0, 1, 0);
    send_row(16, 2'd0, 2'd2, 5, 16, 16'h5000, 0, 0);
    idle(2);
    expect_row(16'h5800, 16, 2'd0, 1'b1, 1, 0);
    send_row(16, 2'd0, 2'd0, 99, 0, 16'h5800, 0, 0);
    idle(3);

    // 6: reset mid-row, then a fresh row
    send_row(8, 2'd0, 2'd0, 99, 0, 16'h6000, 0, 0);
    i_s_valid = 1'b1; i_s_data = 16'h6008; i_rst = 1'b1;
    @(posedge clk); #1;
    chk("midrow_rst_o_valid", 32'(o_valid), 32'd0);
    chk("midrow_rst_ready", 32'(o_s_ready), 32'd0);
    i_rst = 1'b0;
    expect_row(16'h7000, 16, 2'd0, 1'b0, 1, 0);
    send_row(16, 2'd0, 2'd0, 99, 16, 16'h7000, 0, 0);

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    idle(4);
    chk("rows_outstanding", 32'(exp_q.size()), 32'd0);
    chk("rows_emitted", 32'(rowi), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
